// File: rtl/quantize_wb_ctrl_if.sv
// Row-level bus of the write-back sequencer: array input handshake, quantize lane
// pair and SRAM write port. "master" is the controller view, "slave" the environment view.
interface quantize_wb_ctrl_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [ROW_W-1:0]      in_data;
  logic [ROW_W-1:0]      q_ori_data;
  logic [ROW_W-1:0]      q_data;
  logic                  sram_wen;
  logic                  sram_ready;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [ROW_W-1:0]      sram_wdata;

  modport master (
    input  in_valid, in_data, q_data, sram_ready,
    output in_ready, q_ori_data, sram_wen, sram_addr, sram_wdata
  );

  modport slave (
    output in_valid, in_data, q_data, sram_ready,
    input  in_ready, q_ori_data, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/quantize_wb_ctrl.sv
// Write-back sequencer: buffers array rows in a small FIFO, passes the head row
// through the quantize lane and writes the results to consecutive SRAM words.
module quantize_wb_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  output logic                  busy,
  output logic                  done,
  quantize_wb_ctrl_if.master    bus
);
  localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [ROW_W-1:0]      mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop;

  // A full FIFO refuses input even when the head pops in the same cycle.
  assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);

  assign bus.in_ready   = (state_q == RUN) && !fifo_full && (in_cnt_q < num_q);
  assign bus.sram_wen   = (state_q == RUN) && !fifo_empty;
  assign bus.q_ori_data = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.sram_wdata = bus.q_data;
  assign bus.sram_addr  = base_q + out_cnt_q[ADDR_WIDTH-1:0];

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.sram_wen && bus.sram_ready;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          num_d     = num_rows;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (num_rows != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (push) in_cnt_d = in_cnt_q + CNT_W'(1);
        if (pop) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          if (out_cnt_q + CNT_W'(1) == num_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Row storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end
endmodule

// File: tb/tb_quantize_wb_ctrl.sv
// Scoreboard bench for quantize_wb_ctrl: jobs queue their expected SRAM writes,
// a negedge monitor compares every presented write against the queue head.
module tb_quantize_wb_ctrl;
  localparam int AS = 8;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FD = 4;
  localparam int RW = AS * DW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;

  quantize_wb_ctrl_if #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  quantize_wb_ctrl #(
    .ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .busy(busy), .done(done), .bus(bus)
  );

  // The quantize lane is an FP32 pass-through today.
  assign bus.q_data = bus.q_ori_data;

  always #5 clk = ~clk;

  wr_t expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  writeCount = 0;
  int  doneCount = 0;

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rowVal(input int tag, input int row);
    logic [RW-1:0] v;
    v = '0;
    for (int l = 0; l < AS; l++)
      v[l*DW +: DW] = 32'h3F800000 + DW'(l) + DW'(row << 8) + DW'(tag << 16);
    return v;
  endfunction

  // Monitor: every presented write must match the scoreboard head, held while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) doneCount++;
      if (bus.sram_wen) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write addr=%0h expected=no_write", bus.sram_addr);
          if (bus.sram_ready) writeCount++;
        end else begin
          checkOutput("wr_addr", RW'(bus.sram_addr), RW'(expQ[0].addr));
          checkOutput("wr_data", bus.sram_wdata, expQ[0].data);
          if (bus.sram_ready) begin
            void'(expQ.pop_front());
            writeCount++;
          end
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.sram_ready = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("rst_in_ready", RW'(bus.in_ready), '0);
    checkOutput("rst_sram_wen", RW'(bus.sram_wen), '0);
    checkOutput("rst_sram_addr", RW'(bus.sram_addr), '0);
    checkOutput("rst_busy", RW'(busy), '0);
    checkOutput("rst_done", RW'(done), '0);
    checkOutput("rst_q_ori_data", bus.q_ori_data, '0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One job: start at cycle 0, random/held handshakes, optional ignored mid-job
  // start, optional abort by reset after a given number of writes.
  task automatic applyStimulus(input int tag, input logic [AW-1:0] base, input int n,
                               input int vProb, input int rProb, input int holdCycles,
                               input int midStartCyc, input int abortAfter, input int expLat);
    int  rowIdx = 0;
    int  cyc = 0;
    int  wrs = 0;
    int  doneCyc = -1;
    int  wc0 = writeCount;
    int  dc0 = doneCount;
    bit  fin = 0;
    bit  aborted = 0;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + AW'(i);
      e.data = rowVal(tag, i);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = base;
    num_rows = (AW+1)'(n);
    bus.in_valid = (n > 0) && ($urandom_range(99) < vProb);
    bus.in_data = rowVal(tag, 0);
    bus.sram_ready = 1'b0;
    while (!fin) begin
      #3;
      if (holdCycles > 0 && cyc == holdCycles) begin
        checkOutput("bp_rows_accepted", RW'(rowIdx), RW'(FD));
        checkOutput("bp_in_ready", RW'(bus.in_ready), '0);
        checkOutput("bp_sram_wen", RW'(bus.sram_wen), RW'(1));
      end
      if (bus.in_valid && bus.in_ready) rowIdx++;
      if (bus.sram_wen && bus.sram_ready) wrs++;
      if (done) begin
        doneCyc = cyc;
        fin = 1;
        checkOutput("busy_in_done", RW'(busy), RW'(1));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (abortAfter > 0 && wrs == abortAfter) begin
        doReset();
        checkOutput("abort_writes", RW'(writeCount - wc0), RW'(abortAfter));
        checkOutput("abort_no_done", RW'(doneCount - dc0), '0);
        aborted = 1;
        fin = 1;
      end else if (!fin && cyc > n * 20 + 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL job%0d_timeout actual=no_done required=done", tag);
        doReset();
        aborted = 1;
        fin = 1;
      end else begin
        start = (cyc == midStartCyc);
        base_addr = (cyc == midStartCyc) ? 10'h100 : base;
        num_rows = (cyc == midStartCyc) ? 11'd1 : (AW+1)'(n);
        bus.in_valid = (rowIdx < n) && ($urandom_range(99) < vProb);
        bus.in_data = rowVal(tag, rowIdx);
        bus.sram_ready = (cyc > holdCycles) && ($urandom_range(99) < rProb);
      end
    end
    if (!aborted) begin
      checkOutput("busy_after_done", RW'(busy), '0);
      checkOutput("done_one_cycle", RW'(done), '0);
      checkOutput("write_count", RW'(writeCount - wc0), RW'(n));
      checkOutput("done_count", RW'(doneCount - dc0), RW'(1));
      checkOutput("queue_drained", RW'(expQ.size()), '0);
      if (expLat >= 0) checkOutput("done_latency", RW'(doneCyc), RW'(expLat));
    end
    bus.in_valid = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_rows = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.sram_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    doReset();

    $display("[TB] basic job");
    applyStimulus(0, 10'h010, 4, 100, 100, 0, -1, 0, 6);
    $display("[TB] backpressure job");
    applyStimulus(1, 10'h020, 8, 100, 100, 10, -1, 0, -1);
    $display("[TB] address wrap job");
    applyStimulus(2, 10'h3FE, 4, 100, 100, 0, -1, 0, 6);
    $display("[TB] zero-length job");
    applyStimulus(3, 10'h050, 0, 100, 100, 0, -1, 0, 1);
    $display("[TB] ignored mid-job start");
    applyStimulus(4, 10'h060, 5, 100, 100, 0, 3, 0, 7);
    $display("[TB] reset mid-job");
    applyStimulus(5, 10'h040, 6, 100, 100, 0, -1, 2, -1);
    applyStimulus(6, 10'h200, 3, 100, 100, 0, -1, 0, 5);
    $display("[TB] random handshake job");
    applyStimulus(7, 10'h3E0, 64, 70, 60, 0, -1, 0, -1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quantize_wb_ctrl.md
Name: quantize_wb_ctrl

Overview:
Write-back sequencer between the systolic array output and the output SRAM. It accepts row vectors from the array through a valid/ready handshake and buffers them in a small FIFO. Each FIFO head row goes through the external quantize lane stage (FP32 pass-through today), and the result is written to SRAM at consecutive addresses from a programmed base. The block runs one job of N rows per start and reports busy/done.

Parameters:
ARRAY_SIZE, 8, lanes per row
DATA_WIDTH, 32, bits per lane (FP32)
ADDR_WIDTH, 10, SRAM word address width
FIFO_DEPTH, 4, row buffer depth (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  job start pulse, sampled only in IDLE
base_addr  input  ADDR_WIDTH  first SRAM address, latched on accepted start
num_rows  input  ADDR_WIDTH+1  rows in job, latched on accepted start
in_valid  input  1  array row valid
in_ready  output  1  controller can accept a row
in_data  input  ARRAY_SIZE*DATA_WIDTH  array row
q_ori_data  output  ARRAY_SIZE*DATA_WIDTH  FIFO head row, driven to quantize ori_data
q_data  input  ARRAY_SIZE*DATA_WIDTH  quantized_data returned from quantize (combinational)
sram_wen  output  1  write request
sram_ready  input  1  SRAM accepts write this cycle
sram_addr  output  ADDR_WIDTH  write address
sram_wdata  output  ARRAY_SIZE*DATA_WIDTH  write data (= q_data)
busy  output  1  job in progress
done  output  1  one-cycle job-complete pulse

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port rst.
- On rst: state=IDLE, FIFO emptied, in/out counters=0, base_reg=0, num_reg=0.
- Outputs under reset: in_ready=0, sram_wen=0, sram_addr=0, busy=0, done=0, q_ori_data=0.
- rst asserted mid-job aborts the job. Buffered rows are discarded, no further writes are issued, and no done pulse is produced.
- States and transitions:
  - IDLE: start=1 latches base_addr and num_rows. Goes to RUN if num_rows!=0, otherwise to DONE.
  - RUN: accepts and writes rows. Goes to DONE on the cycle the num_reg-th write handshakes.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and DONE.
- start outside IDLE is ignored. It has no effect on latched values or counters.
- Input side:
  - in_ready = (state==RUN) && !fifo_full && (in_cnt<num_reg).
  - A row is pushed when in_valid && in_ready. in_cnt then increments.
  - While full, in_ready stays 0 even if a pop occurs the same cycle. There is no same-cycle push-through on a full FIFO.
- Output side:
  - sram_wen = (state==RUN) && !fifo_empty.
  - q_ori_data is the FIFO head, or 0 when empty.
  - sram_wdata = q_data.
  - sram_addr = base_reg + out_cnt, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - A write completes when sram_wen && sram_ready. The head is then popped and out_cnt increments.
  - While sram_ready=0, sram_wen, sram_addr and sram_wdata hold stable.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Latency: a row pushed into an empty FIFO at edge k has sram_wen=1 in cycle k+1. Its write completes at the first edge with sram_ready=1.
- Throughput: 1 row/cycle sustained when in_valid=1 and sram_ready=1 continuously.
- Counters are ADDR_WIDTH+1 bits. num_rows up to 2^ADDR_WIDTH is legal. Addresses wrap, counters do not.
- Rows arriving after in_cnt==num_reg are not accepted. in_ready=0, and the array must hold them.
- done asserts the cycle after the final write handshake. busy deasserts one cycle later.

Test Plan:
- Basic: base_addr=0x010, num_rows=4, in_valid and sram_ready held 1, rows with lane i = 0x3F800000+i -> writes at 0x010..0x013 on consecutive cycles, data identical to input, done pulses once, busy drops next cycle.
- Backpressure: FIFO_DEPTH=4, num_rows=8, sram_ready=0 for 10 cycles -> exactly 4 rows accepted then in_ready=0, sram_wen=1 with addr/data stable. After release, 8 writes complete in order.
- Wrap: base_addr=0x3FE, num_rows=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001, and done asserts.
- Zero-length/ignored start: num_rows=0 -> done the cycle after start with no sram_wen. A start pulse mid-job with base_addr=0x100 -> no change to the running job's addresses.
- Reset mid-job: rst after 2 of 6 writes -> all outputs 0 immediately and FIFO empty. A new job with num_rows=3 starts cleanly at its own base.
- Random handshake: random in_valid/sram_ready for num_rows=64 -> scoreboard confirms in-order data, contiguous addresses, exactly 64 writes and one done.
